snn_image_loader: RTL and testbench
===================================

# snn_image_loader

Writer side of the SNN input-image RAM. Receives the 784-pixel binary image as 98 packed bytes from the UART receiver and unpacks each byte into eight single-bit writes to the 1-bit-wide input RAM that snn_core later reads. It then pulses `strt` to snn_core, waits for `done`, and hands the classified digit to the UART transmitter.

## Interface
- NUM_PIXELS, 784, image size in pixels; must be a multiple of 8.
- ADDR_W, 10, RAM address width; 2**ADDR_W >= NUM_PIXELS.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte; valid only while rx_rdy is high.
- rx_rdy  in  1  one-cycle pulse per received byte.
- ram_we  out  1  input-RAM write enable.
- ram_addr  out  ADDR_W  input-RAM write address.
- ram_data  out  1  pixel bit to write.
- strt  out  1  one-cycle start pulse to snn_core.
- done  in  1  snn_core completion; sampled high for one or more cycles.
- digit  in  4  snn_core result; valid when done is high.
- tx_start  out  1  one-cycle pulse to the UART transmitter.
- tx_data  out  8  byte to transmit: {4'h0, digit}.
- busy  out  1  high from the first rx_rdy of an image until tx_start.
- overrun  out  1  sticky error flag; cleared only by rst.

## Operation
- States: IDLE, WRITE, START, WAIT_DONE, TX.
- Registers:
  - pix_cnt (ADDR_W bits), the next RAM address.
  - shift, the current byte.
  - bit_cnt (3 bits).
  - pend and pend_vld, a one-deep byte buffer.
- IDLE:
  - rx_rdy loads shift <= rx_data, bit_cnt <= 0, busy <= 1, and moves to WRITE.
- WRITE, each cycle:
  - ram_we = 1, ram_addr = pix_cnt, ram_data = shift[bit_cnt] (LSB first).
  - pix_cnt and bit_cnt increment.
- End of a byte (bit_cnt == 7):
  - If pix_cnt == NUM_PIXELS-1, go to START.
  - Else if pend_vld, or rx_rdy is high this same cycle, load shift from that byte and stay in WRITE with no gap cycle. pend has priority; a simultaneous rx_rdy goes into pend.
  - Else go to IDLE-wait. This is still WRITE with ram_we = 0, waiting for the next rx_rdy; busy stays 1.
- rx_rdy during active WRITE:
  - Stored into pend, pend_vld <= 1.
  - If pend_vld is already 1, the byte is dropped and overrun <= 1.
- START:
  - strt = 1 for exactly one cycle, then WAIT_DONE.
  - pix_cnt <= 0.
- WAIT_DONE:
  - When done is sampled high: capture tx_data <= {4'h0, digit}, go to TX.
- TX:
  - tx_start = 1 for one cycle, busy <= 0, go to IDLE.
- rx_rdy in START, WAIT_DONE or TX: byte dropped, overrun <= 1.
- A byte left in pend when the 784th pixel is written: discarded, overrun <= 1.
- ram_we is never asserted outside WRITE. ram_addr never exceeds NUM_PIXELS-1.

## Timing
- Reset values:
  - All outputs 0: ram_we, ram_addr, ram_data, strt, tx_start, tx_data, busy, overrun.
  - State IDLE; pix_cnt, bit_cnt and pend_vld 0.
- Byte writes: rx_rdy sampled on edge k gives writes on cycles k+1 … k+8, addresses base … base+7.
- Back-to-back bytes: the next byte's first write follows on cycle k+9 when it is pending.
- strt: high on the cycle after the write to address NUM_PIXELS-1.
- tx_start: high on the cycle after done is first sampled high. done held for several cycles produces only one tx_start.
- All outputs are registered. No combinational path from any input to any output.
- rst asserted at any point (mid-byte, mid-image, WAIT_DONE):
  - Immediately returns everything to reset values.
  - The next image starts at address 0.
  - A partially written image is not cleared from RAM.

## Test plan
- Reset, then 98 bytes of 8'hA5 with rx_rdy spaced 20 cycles -> 784 writes; addr n gets bit (n mod 8) of 8'hA5 (addr 0 = 1, addr 1 = 0); one strt pulse after addr 783; overrun = 0.
- Same image, then done high for 3 cycles with digit = 4'd7 -> exactly one tx_start, tx_data = 8'h07, busy falls with it.
- Two rx_rdy pulses 1 cycle apart -> 16 consecutive write cycles with no gap; third pulse inside that window -> overrun = 1 and the third byte is never written.
- rx_rdy on the same cycle as bit 7 of the current byte -> writes continue on the next cycle with the new byte's bit 0; overrun stays 0.
- rst asserted after 40 bytes -> all outputs 0; a following full 98-byte image writes from addr 0 and strt fires after addr 783.
- rx_rdy during WAIT_DONE -> no ram_we, overrun = 1, tx_start still issued when done arrives.

Source files
------------

// File: rtl/snn_image_loader.sv
// ---------------------------------------------------------------------------------------------
// snn_image_loader
//
// Writer side of the SNN input-image RAM. Packed image bytes arrive from the UART receiver and
// are unpacked LSB first into single-bit writes of the 1-bit-wide input RAM. When the last
// pixel has been written, snn_core is started. Its result is then handed to the UART
// transmitter as {4'h0, digit}.
//
// Ports
//   clk       system clock, all logic on the rising edge
//   rst       asynchronous active-high reset
//   rx_data   received byte, valid while rx_rdy is high
//   rx_rdy    one-cycle pulse per received byte
//   ram_we    input-RAM write enable
//   ram_addr  input-RAM write address (never above NUM_PIXELS-1)
//   ram_data  pixel bit being written
//   strt      one-cycle start pulse to snn_core
//   done      snn_core completion (may be held for several cycles)
//   digit     snn_core result, valid with done
//   tx_start  one-cycle pulse to the UART transmitter
//   tx_data   byte to transmit, {4'h0, digit}
//   busy      high from the first byte of an image until tx_start
//   overrun   sticky dropped-byte flag, cleared only by rst
//
// Every output is a flop. The output flops are loaded from the next-state values, so a byte
// sampled on edge k shows its first pixel write right after that same edge.
// ---------------------------------------------------------------------------------------------
module snn_image_loader #(
  parameter int unsigned NUM_PIXELS = 784,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              strt,
  input  logic              done,
  input  logic [3:0]        digit,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              overrun
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWrite    = 3'd1;
  localparam logic [2:0] StStart    = 3'd2;
  localparam logic [2:0] StWaitDone = 3'd3;
  localparam logic [2:0] StTx       = 3'd4;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_PIXELS - 1);

  // Control state
  logic [2:0]        r_state,    w_state_d;
  logic [ADDR_W-1:0] r_pix_cnt,  w_pix_cnt_d;
  logic [7:0]        r_shift,    w_shift_d;
  logic [2:0]        r_bit_cnt,  w_bit_cnt_d;
  logic [7:0]        r_pend,     w_pend_d;
  logic              r_pend_vld, w_pend_vld_d;
  // Inside StWrite: 1 while bits are being written, 0 while waiting for the next byte.
  logic              r_active,   w_active_d;
  logic              r_busy,     w_busy_d;
  logic              r_overrun,  w_overrun_d;
  logic [7:0]        r_tx_data,  w_tx_data_d;

  // Output flops
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_data;
  logic              r_strt;
  logic              r_tx_start;

  logic              w_we_d;

  // -------------------------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------------------------
  always_comb begin
    w_state_d    = r_state;
    w_pix_cnt_d  = r_pix_cnt;
    w_shift_d    = r_shift;
    w_bit_cnt_d  = r_bit_cnt;
    w_pend_d     = r_pend;
    w_pend_vld_d = r_pend_vld;
    w_active_d   = r_active;
    w_busy_d     = r_busy;
    w_overrun_d  = r_overrun;
    w_tx_data_d  = r_tx_data;

    case (r_state)
      StIdle: begin
        if (rx_rdy) begin
          w_shift_d   = rx_data;
          w_bit_cnt_d = 3'd0;
          w_active_d  = 1'b1;
          w_busy_d    = 1'b1;
          w_state_d   = StWrite;
        end
      end

      StWrite: begin
        if (r_active) begin
          if (r_bit_cnt == 3'd7) begin
            if (r_pix_cnt == LastAddr) begin
              // Image complete: anything still buffered or arriving now has nowhere to go.
              if (r_pend_vld || rx_rdy) begin
                w_overrun_d = 1'b1;
              end
              w_pend_vld_d = 1'b0;
              w_active_d   = 1'b0;
              w_bit_cnt_d  = 3'd0;
              w_pix_cnt_d  = '0;
              w_state_d    = StStart;
            end else begin
              w_pix_cnt_d = r_pix_cnt + ADDR_W'(1);
              w_bit_cnt_d = 3'd0;
              if (r_pend_vld) begin
                // Buffered byte goes first; a byte arriving now takes its place in pend.
                w_shift_d    = r_pend;
                w_pend_vld_d = rx_rdy;
                if (rx_rdy) begin
                  w_pend_d = rx_data;
                end
              end else if (rx_rdy) begin
                w_shift_d = rx_data;
              end else begin
                w_active_d = 1'b0;
              end
            end
          end else begin
            w_pix_cnt_d = r_pix_cnt + ADDR_W'(1);
            w_bit_cnt_d = r_bit_cnt + 3'd1;
            if (rx_rdy) begin
              if (r_pend_vld) begin
                w_overrun_d = 1'b1;
              end else begin
                w_pend_d     = rx_data;
                w_pend_vld_d = 1'b1;
              end
            end
          end
        end else if (rx_rdy) begin
          // Waiting between bytes; pend is always empty here.
          w_shift_d   = rx_data;
          w_bit_cnt_d = 3'd0;
          w_active_d  = 1'b1;
        end
      end

      StStart: begin
        w_pix_cnt_d = '0;
        if (rx_rdy) begin
          w_overrun_d = 1'b1;
        end
        w_state_d = StWaitDone;
      end

      StWaitDone: begin
        if (rx_rdy) begin
          w_overrun_d = 1'b1;
        end
        if (done) begin
          w_tx_data_d = {4'h0, digit};
          w_busy_d    = 1'b0;
          w_state_d   = StTx;
        end
      end

      StTx: begin
        if (rx_rdy) begin
          w_overrun_d = 1'b1;
        end
        w_state_d = StIdle;
      end

      default: begin
        w_state_d  = StIdle;
        w_active_d = 1'b0;
      end
    endcase
  end

  // A write happens in every cycle spent actively unpacking a byte.
  assign w_we_d = (w_state_d == StWrite) && w_active_d;

  // -------------------------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_pix_cnt  <= '0;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_pend     <= 8'h00;
      r_pend_vld <= 1'b0;
      r_active   <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_state_d;
      r_pix_cnt  <= w_pix_cnt_d;
      r_shift    <= w_shift_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_pend     <= w_pend_d;
      r_pend_vld <= w_pend_vld_d;
      r_active   <= w_active_d;
      r_busy     <= w_busy_d;
      r_overrun  <= w_overrun_d;
      r_tx_data  <= w_tx_data_d;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= 1'b0;
      r_strt     <= 1'b0;
      r_tx_start <= 1'b0;
    end else begin
      r_ram_we   <= w_we_d;
      // Address holds its last written value between writes so it never leaves the image.
      if (w_we_d) begin
        r_ram_addr <= w_pix_cnt_d;
      end
      r_ram_data <= w_we_d & w_shift_d[w_bit_cnt_d];
      r_strt     <= (w_state_d == StStart);
      r_tx_start <= (w_state_d == StTx);
    end
  end

  assign ram_we   = r_ram_we;
  assign ram_addr = r_ram_addr;
  assign ram_data = r_ram_data;
  assign strt     = r_strt;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_snn_image_loader.sv
// ---------------------------------------------------------------------------------------------
// Testbench for snn_image_loader. A transaction-level model (byte queue plus start/end edge
// timestamps) predicts every output each cycle; directed literal checks pin down the model.
// ---------------------------------------------------------------------------------------------
module tb_snn_image_loader;

  localparam int unsigned NumPixels = 784;
  localparam int unsigned AddrW     = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_rdy = 1'b0;
  logic             done = 1'b0;
  logic [3:0]       digit = 4'h0;
  logic             ram_we;
  logic [AddrW-1:0] ram_addr;
  logic             ram_data;
  logic             strt;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             busy;
  logic             overrun;

  always #5 clk = ~clk;

  snn_image_loader #(
    .NUM_PIXELS(NumPixels),
    .ADDR_W    (AddrW)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .ram_we  (ram_we),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .strt    (strt),
    .done    (done),
    .digit   (digit),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .busy    (busy),
    .overrun (overrun)
  );

  // -------------------------------------------------------------------------------------------
  // Reference model: each accepted byte is scheduled to write during the 8 cycles following the
  // edge it starts on; the writer frees up on the 8th edge after that.
  // -------------------------------------------------------------------------------------------
  int         cyc = 0;
  int         m_mode = 0;            // 0 loading, 1 start, 2 waiting for done, 3 transmit
  bit         m_writing = 1'b0;
  int         m_start = 0;
  int         m_base = 0;
  int         m_next = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_pend_q[$];
  bit         m_busy = 1'b0;
  bit         m_ovr = 1'b0;
  logic [7:0] m_txd = 8'h00;
  bit         e_we = 1'b0;
  bit         e_strt = 1'b0;
  bit         e_txs = 1'b0;
  int         e_addr = 0;
  bit         e_data = 1'b0;

  task m_begin_byte(input logic [7:0] b);
    m_byte    = b;
    m_start   = cyc;
    m_base    = m_next;
    m_next    = m_next + 8;
    m_writing = 1'b1;
    m_busy    = 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; m_mode = 0; m_writing = 1'b0; m_next = 0; m_pend_q.delete();
      m_busy = 1'b0; m_ovr = 1'b0; m_txd = 8'h00;
      e_we = 1'b0; e_strt = 1'b0; e_txs = 1'b0; e_addr = 0; e_data = 1'b0;
    end else begin
      cyc++;
      e_strt = 1'b0;
      e_txs  = 1'b0;
      case (m_mode)
        0: begin
          if (m_writing && cyc < m_start + 8) begin
            if (rx_rdy) begin
              if (m_pend_q.size() == 0) m_pend_q.push_back(rx_data);
              else m_ovr = 1'b1;
            end
          end else begin
            if (m_writing) begin
              m_writing = 1'b0;
              if (m_next == NumPixels) begin
                if (rx_rdy || m_pend_q.size() != 0) m_ovr = 1'b1;
                m_pend_q.delete();
                m_mode = 1;
                e_strt = 1'b1;
              end
            end
            if (m_mode == 0) begin
              if (m_pend_q.size() != 0) begin
                m_begin_byte(m_pend_q.pop_front());
                if (rx_rdy) m_pend_q.push_back(rx_data);
              end else if (rx_rdy) begin
                m_begin_byte(rx_data);
              end
            end
          end
        end
        1: begin
          if (rx_rdy) m_ovr = 1'b1;
          m_mode = 2;
        end
        2: begin
          if (rx_rdy) m_ovr = 1'b1;
          if (done) begin
            m_txd  = {4'h0, digit};
            m_busy = 1'b0;
            e_txs  = 1'b1;
            m_mode = 3;
          end
        end
        default: begin
          if (rx_rdy) m_ovr = 1'b1;
          m_mode = 0;
          m_next = 0;
        end
      endcase
      e_we = m_writing;
      if (m_writing) begin
        e_addr = m_base + (cyc - m_start);
        e_data = m_byte[cyc-m_start];
      end
    end
  end

  // -------------------------------------------------------------------------------------------
  // Checking, monitoring and stimulus (single process)
  // -------------------------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  bit wr_mem[0:1023];
  int wr_cnt, first_addr, last_addr, strt_cnt, txs_cnt, run_len, max_run;
  bit busy_at_txs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle_checks();
    if (rst) begin
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_data", 32'(ram_data), 32'd0);
      chk("rst_strt", 32'(strt), 32'd0);
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
    end else begin
      chk("ram_we", 32'(ram_we), 32'(e_we));
      if (e_we) begin
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_data", 32'(ram_data), 32'(e_data));
      end
      chk("strt", 32'(strt), 32'(e_strt));
      chk("tx_start", 32'(tx_start), 32'(e_txs));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("tx_data", 32'(tx_data), 32'(m_txd));
    end
  endtask

  task automatic monitor();
    if (ram_we === 1'b1) begin
      if (wr_cnt == 0) first_addr = int'(ram_addr);
      last_addr = int'(ram_addr);
      wr_mem[ram_addr] = ram_data;
      wr_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (strt === 1'b1) strt_cnt++;
    if (tx_start === 1'b1) begin
      txs_cnt++;
      busy_at_txs = busy;
    end
  endtask

  task automatic mon_clear();
    for (int i = 0; i < 1024; i++) wr_mem[i] = 1'b0;
    wr_cnt = 0; first_addr = -1; last_addr = -1; strt_cnt = 0; txs_cnt = 0;
    run_len = 0; max_run = 0; busy_at_txs = 1'b1;
  endtask

  // Compare on the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    cycle_checks();
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
  endtask

  initial begin
    mon_clear();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    chk("reset_ram_addr", 32'(ram_addr), 32'd0);
    chk("reset_ram_data", 32'(ram_data), 32'd0);
    chk("reset_strt", 32'(strt), 32'd0);
    chk("reset_tx_start", 32'(tx_start), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);

    // Image 1: 98 x 8'hA5, bytes 20 cycles apart
    mon_clear();
    for (int i = 0; i < 98; i++) begin
      send(8'hA5);
      repeat (19) tick();
    end
    chk("img1_writes", 32'(wr_cnt), 32'd784);
    chk("img1_first_addr", 32'(first_addr), 32'd0);
    chk("img1_last_addr", 32'(last_addr), 32'd783);
    chk("img1_addr0", 32'(wr_mem[0]), 32'd1);
    chk("img1_addr1", 32'(wr_mem[1]), 32'd0);
    chk("img1_addr2", 32'(wr_mem[2]), 32'd1);
    chk("img1_addr5", 32'(wr_mem[5]), 32'd1);
    chk("img1_addr783", 32'(wr_mem[783]), 32'd1);
    chk("img1_run", 32'(max_run), 32'd8);
    chk("img1_strt_cnt", 32'(strt_cnt), 32'd1);
    chk("img1_overrun", 32'(overrun), 32'd0);
    chk("img1_busy_wait", 32'(busy), 32'd1);

    // done held for 3 cycles with digit 7
    done  = 1'b1;
    digit = 4'd7;
    repeat (3) tick();
    done  = 1'b0;
    digit = 4'd9;
    repeat (5) tick();
    chk("img1_txs_cnt", 32'(txs_cnt), 32'd1);
    chk("img1_tx_data", 32'(tx_data), 32'h07);
    chk("img1_busy_at_txs", 32'(busy_at_txs), 32'd0);
    chk("img1_busy_after", 32'(busy), 32'd0);

    // Two back-to-back bytes, a third one inside their write window
    mon_clear();
    send(8'h3C);
    send(8'hC3);
    tick();
    send(8'hFF);
    repeat (25) tick();
    chk("burst_writes", 32'(wr_cnt), 32'd16);
    chk("burst_run", 32'(max_run), 32'd16);
    chk("burst_last_addr", 32'(last_addr), 32'd15);
    chk("burst_addr0", 32'(wr_mem[0]), 32'd0);
    chk("burst_addr2", 32'(wr_mem[2]), 32'd1);
    chk("burst_addr8", 32'(wr_mem[8]), 32'd1);
    chk("burst_addr10", 32'(wr_mem[10]), 32'd0);
    chk("burst_addr14", 32'(wr_mem[14]), 32'd1);
    chk("burst_overrun", 32'(overrun), 32'd1);

    // 40 more bytes, then reset in the middle of the last one
    for (int i = 0; i < 40; i++) begin
      send(8'(i * 3 + 1));
      repeat (7) tick();
    end
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_we", 32'(ram_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_ram_we", 32'(ram_we), 32'd0);
    chk("midrst_ram_addr", 32'(ram_addr), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    repeat (2) tick();
    rst = 1'b0;

    // Image 2: bytes arrive exactly on the bit-7 cycle of the previous byte
    mon_clear();
    for (int i = 0; i < 98; i++) begin
      send(8'(i * 29 + 7));
      repeat (7) tick();
    end
    repeat (3) tick();
    chk("img2_writes", 32'(wr_cnt), 32'd784);
    chk("img2_first_addr", 32'(first_addr), 32'd0);
    chk("img2_last_addr", 32'(last_addr), 32'd783);
    chk("img2_run", 32'(max_run), 32'd784);
    chk("img2_addr0", 32'(wr_mem[0]), 32'd1);
    chk("img2_addr3", 32'(wr_mem[3]), 32'd0);
    chk("img2_addr8", 32'(wr_mem[8]), 32'd0);
    chk("img2_addr10", 32'(wr_mem[10]), 32'd1);
    chk("img2_addr778", 32'(wr_mem[778]), 32'd1);
    chk("img2_addr783", 32'(wr_mem[783]), 32'd0);
    chk("img2_strt_cnt", 32'(strt_cnt), 32'd1);
    chk("img2_overrun_clean", 32'(overrun), 32'd0);

    // Byte during WAIT_DONE is dropped
    send(8'h55);
    repeat (3) tick();
    chk("wait_rx_overrun", 32'(overrun), 32'd1);
    chk("wait_rx_no_write", 32'(wr_cnt), 32'd784);
    done  = 1'b1;
    digit = 4'd3;
    tick();
    done  = 1'b0;
    digit = 4'd0;
    repeat (4) tick();
    chk("img2_txs_cnt", 32'(txs_cnt), 32'd1);
    chk("img2_tx_data", 32'(tx_data), 32'h03);
    chk("img2_busy_after", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
